host_cmd_frontend: RTL and testbench
====================================

HOST_CMD_FRONTEND -- requirements
Module: host_cmd_frontend

Interface
REQ-001 SHALL have parameter WORDS_PER_INSTR, default 4, meaning 32-bit host words per assembled instruction (2..8).
REQ-002 SHALL have parameter DEPTH, default 8, meaning instruction FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port h2f_pio32  input  32  host MMIO data word.
REQ-006 SHALL have port h2f_write  input  1  one-cycle strobe qualifying h2f_pio32.
REQ-007 SHALL have port instr_data  output  32*WORDS_PER_INSTR  FIFO head instruction for the ctrl_unit.
REQ-008 SHALL have port instr_valid  output  1  head instruction present.
REQ-009 SHALL have port instr_ready  input  1  ctrl_unit consumes head.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-011 SHALL have port partial  output  1  assembler holds 1..WORDS_PER_INSTR-1 words.
REQ-012 SHALL have port overflow  output  1  sticky flag: instruction dropped.
REQ-013 SHALL have port clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-014 Assembler SHALL store word k of an instruction (k = 0 first) into bits [32k+31:32k] of a staging register on each h2f_write.
REQ-015 Word index SHALL increment per h2f_write and wrap to 0 after word WORDS_PER_INSTR-1.
REQ-016 On the write carrying the last word (cycle N), the complete instruction SHALL be pushed into the FIFO at the clock edge ending cycle N; instr_valid SHALL be high in cycle N+1 if the FIFO was empty.
REQ-017 FIFO SHALL be first-word-fall-through: instr_data SHALL equal the oldest entry whenever instr_valid is high, and SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-018 Pop SHALL occur on a clock edge with instr_valid=1 and instr_ready=1; instr_ready with instr_valid=0 SHALL have no effect.
REQ-019 instr_valid SHALL equal (level != 0); level SHALL update by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-020 Push when level=DEPTH SHALL be accepted only if a pop occurs on the same edge; otherwise the instruction SHALL be discarded, overflow set to 1, FIFO contents and level unchanged.
REQ-021 Word index SHALL wrap to 0 after a last word regardless of whether the push was accepted or dropped.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-023 overflow SHALL remain 1 until clr_overflow=1 on a clock edge; if clr_overflow and a new drop coincide, overflow SHALL be 1 after the edge.
REQ-024 partial SHALL be 1 exactly when word index != 0.

Reset
REQ-025 While rst_n=0: instr_valid=0, level=0, partial=0, overflow=0, instr_data=0, pointers and word index 0.
REQ-026 Reset asserted mid-assembly or with a non-empty FIFO SHALL discard all staged words and queued instructions; h2f_write during reset SHALL be ignored.

Configuration
REQ-027 Macro HOST_CMD_RESYNC_EN: when defined, an h2f_write with h2f_pio32=32'hFFFF_FFFF SHALL reset the word index to 0, discard staged words, not be stored, and cause no push; when undefined, 32'hFFFF_FFFF SHALL be treated as ordinary data.

Verification
REQ-028 Writes 0x11,0x22,0x33,0x44 on consecutive cycles, instr_ready=0 -> instr_valid=1 the cycle after 0x44, instr_data=0x00000044_00000033_00000022_00000011, level=1.
REQ-029 Push 8 instructions with instr_ready=0, then a 9th -> level=8, overflow=1, head unchanged; clr_overflow pulse -> overflow=0.
REQ-030 level=8, 9th instruction's last word coincides with instr_ready=1 -> pop and push both occur, level stays 8, overflow=0, newest entry appears after 7 more pops.
REQ-031 Two words written then rst_n pulsed low asynchronously -> partial=0, level=0 immediately; next 4 writes form one complete instruction from those words only.
REQ-032 HOST_CMD_RESYNC_EN defined: writes 0xA,0xB,0xFFFFFFFF,0x1,0x2,0x3,0x4 -> exactly one instruction, instr_data=0x4_3_2_1 word-wise, partial=0; undefined: 0xFFFFFFFF stored as word 2 and data 0xA,0xB,0xFFFFFFFF,0x1 forms the first instruction.

Source files
------------

// File: rtl/host_cmd_frontend.sv
// Assembles WORDS_PER_INSTR host MMIO words into one instruction and queues it in a FWFT FIFO.
// Optional build macro HOST_CMD_RESYNC_EN: an all-ones host word resynchronises the assembler.
module host_cmd_frontend #(
  parameter int WORDS_PER_INSTR = 4,
  parameter int DEPTH           = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   h2f_pio32,
  input  logic                          h2f_write,
  output logic [32*WORDS_PER_INSTR-1:0] instr_data,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          partial,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int IW = 32 * WORDS_PER_INSTR;
  localparam int PW = $clog2(DEPTH);
  localparam int XW = $clog2(WORDS_PER_INSTR);
  localparam int LW = PW + 1;
  localparam logic [XW-1:0] LAST_IDX = XW'(WORDS_PER_INSTR - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [IW-1:0] stage_q;
  logic [IW-1:0] assembled;
  logic [XW-1:0] idx_q;
  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level_q;
  logic          ovf_q;
  logic          resync;
  logic          data_wr;
  logic          last_wr;
  logic          pop;
  logic          push;
  logic          drop;

  always_comb begin
    resync = 1'b0;
`ifdef HOST_CMD_RESYNC_EN
    resync = h2f_write && (h2f_pio32 == 32'hFFFF_FFFF);
`endif
    data_wr   = h2f_write && !resync;
    last_wr   = data_wr && (idx_q == LAST_IDX);
    pop       = (level_q != '0) && instr_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push      = last_wr && ((level_q != FULL_LVL) || pop);
    drop      = last_wr && (level_q == FULL_LVL) && !pop;
    assembled = stage_q;
    assembled[IW-1 -: 32] = h2f_pio32;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      idx_q   <= '0;
    end else if (resync) begin
      stage_q <= '0;
      idx_q   <= '0;
    end else if (data_wr) begin
      stage_q[{idx_q, 5'd0} +: 32] <= h2f_pio32;
      idx_q <= last_wr ? '0 : idx_q + 1'b1;
    end
  end

  // Storage is left unreset; reads are masked by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= assembled;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ovf_q <= 1'b0;
    else if (drop)         ovf_q <= 1'b1;
    else if (clr_overflow) ovf_q <= 1'b0;
  end

  assign instr_valid = (level_q != '0);
  assign instr_data  = instr_valid ? mem[rd_ptr] : '0;
  assign level       = level_q;
  assign partial     = (idx_q != '0);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_host_cmd_frontend.sv
// Bench for host_cmd_frontend: directed scenarios plus random traffic against a queue-based model.
module tb_host_cmd_frontend;
  localparam int W = 4;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   h2f_pio32 = '0;
  logic          h2f_write = 1'b0;
  logic [32*W-1:0] instr_data;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [3:0]    level;
  logic          partial;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]     m_words[$];
  logic [32*W-1:0] m_fifo[$];
  logic            m_ovf = 1'b0;

  host_cmd_frontend #(.WORDS_PER_INSTR(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .h2f_pio32(h2f_pio32), .h2f_write(h2f_write),
    .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .level(level), .partial(partial), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_words.delete();
    m_fifo.delete();
    m_ovf = 1'b0;
  endtask

  // Reference: pop the head if offered, then append the word and enqueue a full instruction.
  task automatic model_step(input logic w, input logic [31:0] d, input logic rdy, input logic clr);
    logic [32*W-1:0] ins;
    bit drop;
    bit is_resync;
    drop = 0;
    is_resync = 0;
    if (rdy && m_fifo.size() != 0) void'(m_fifo.pop_front());
    if (w) begin
`ifdef HOST_CMD_RESYNC_EN
      is_resync = (d == 32'hFFFF_FFFF);
`endif
      if (is_resync) m_words.delete();
      else m_words.push_back(d);
      if (m_words.size() == W) begin
        ins = '0;
        for (int i = 0; i < W; i++) ins[32*i +: 32] = m_words[i];
        m_words.delete();
        if (m_fifo.size() < D) m_fifo.push_back(ins);
        else drop = 1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic w, input logic [31:0] d, input logic rdy, input logic clr);
    h2f_write = w; h2f_pio32 = d; instr_ready = rdy; clr_overflow = clr;
    model_step(w, d, rdy, clr);
    @(posedge clk); #1;
    h2f_write = 1'b0; instr_ready = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic write_instr(input logic [31:0] base);
    for (int k = 0; k < W; k++) cycle(1'b1, base + 32'(k), 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i <= D; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    h2f_write = 1'b1; h2f_pio32 = 32'hDEAD_BEEF; instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    h2f_write = 1'b0; instr_ready = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (partial !== 1'b0) begin n_err++; $display("FAIL reset_partial: got %b want 0", partial); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (instr_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", instr_data); end
    rst_n = 1'b1;
    model_clear();
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    n_cmp++; if (partial !== 1'b1) begin n_err++; $display("FAIL basic_partial: got %b want 1", partial); end
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, 1'b0);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", instr_valid); end
    cycle(1'b1, 32'h44, 1'b0, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr_data !== 128'h00000044_00000033_00000022_00000011) begin
      n_err++; $display("FAIL basic_data: got %h want 00000044000000330000002200000011", instr_data); end
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL basic_level: got %0d want 1", level); end
    n_cmp++; if (partial !== 1'b0) begin n_err++; $display("FAIL basic_partial_end: got %b want 0", partial); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (instr_data !== 128'h00000044_00000033_00000022_00000011) begin
      n_err++; $display("FAIL basic_hold: got %h", instr_data); end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) write_instr(32'h100 * 32'(i + 1));
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL ovf_fill_level: got %0d want 8", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow); end
    write_instr(32'h900);
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL ovf_level: got %0d want 8", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (instr_data !== {32'h103, 32'h102, 32'h101, 32'h100}) begin
      n_err++; $display("FAIL ovf_head: got %h want 00000103000001020000010100000100", instr_data); end
    n_cmp++; if (partial !== 1'b0) begin n_err++; $display("FAIL ovf_partial: got %b want 0", partial); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    drain();
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < D; i++) write_instr(32'h1000 * 32'(i + 1));
    for (int k = 0; k < W - 1; k++) cycle(1'b1, 32'h9000 + 32'(k), 1'b0, 1'b0);
    cycle(1'b1, 32'h9003, 1'b1, 1'b0);
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL pp_level: got %0d want 8", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_overflow: got %b want 0", overflow); end
    n_cmp++; if (instr_data !== {32'h2003, 32'h2002, 32'h2001, 32'h2000}) begin
      n_err++; $display("FAIL pp_second_head: got %h", instr_data); end
    for (int i = 0; i < D - 1; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL pp_last_level: got %0d want 1", level); end
    n_cmp++; if (instr_data !== {32'h9003, 32'h9002, 32'h9001, 32'h9000}) begin
      n_err++; $display("FAIL pp_newest: got %h want 00009003000090020000900100009000", instr_data); end
    drain();
  endtask

  task automatic test_async_reset();
    write_instr(32'h700);
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    cycle(1'b1, 32'h66, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (partial !== 1'b0) begin n_err++; $display("FAIL arst_partial: got %b want 0", partial); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL arst_level: got %0d want 0", level); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", instr_valid); end
    @(posedge clk); #1;
    h2f_write = 1'b1; h2f_pio32 = 32'h77;
    @(posedge clk); #1;
    h2f_write = 1'b0;
    rst_n = 1'b1;
    model_clear();
    for (int k = 1; k <= W; k++) cycle(1'b1, 32'(k), 1'b0, 1'b0);
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL arst_after_level: got %0d want 1", level); end
    n_cmp++; if (instr_data !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
      n_err++; $display("FAIL arst_after_data: got %h want 00000004000000030000000200000001", instr_data); end
    drain();
  endtask

  task automatic test_resync();
    logic [31:0] seq [7];
    seq = '{32'hA, 32'hB, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3, 32'h4};
    for (int i = 0; i < 7; i++) cycle(1'b1, seq[i], 1'b0, 1'b0);
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL resync_level: got %0d want 1", level); end
`ifdef HOST_CMD_RESYNC_EN
    n_cmp++; if (instr_data !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
      n_err++; $display("FAIL resync_data: got %h want 00000004000000030000000200000001", instr_data); end
    n_cmp++; if (partial !== 1'b0) begin n_err++; $display("FAIL resync_partial: got %b want 0", partial); end
`else
    n_cmp++; if (instr_data !== {32'h1, 32'hFFFF_FFFF, 32'hB, 32'hA}) begin
      n_err++; $display("FAIL resync_data: got %h want 00000001ffffffff0000000b0000000a", instr_data); end
    n_cmp++; if (partial !== 1'b1) begin n_err++; $display("FAIL resync_partial: got %b want 1", partial); end
    cycle(1'b1, 32'h5, 1'b0, 1'b0);
`endif
    drain();
  endtask

  task automatic test_random();
    logic            w, rdy, clr;
    logic [31:0]     d;
    logic [32*W-1:0] exp_data;
    for (int n = 0; n < 600; n++) begin
      w   = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 15) == 0);
      d   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      cycle(w, d, rdy, clr);
      exp_data = (m_fifo.size() != 0) ? m_fifo[0] : '0;
      n_cmp++; if (instr_valid !== (m_fifo.size() != 0)) begin
        n_err++; $display("FAIL rnd_valid @%0d: got %b want %b", n, instr_valid, m_fifo.size() != 0); end
      n_cmp++; if (level !== 4'(m_fifo.size())) begin
        n_err++; $display("FAIL rnd_level @%0d: got %0d want %0d", n, level, m_fifo.size()); end
      n_cmp++; if (instr_data !== exp_data) begin
        n_err++; $display("FAIL rnd_data @%0d: got %h want %h", n, instr_data, exp_data); end
      n_cmp++; if (partial !== (m_words.size() != 0)) begin
        n_err++; $display("FAIL rnd_partial @%0d: got %b want %b", n, partial, m_words.size() != 0); end
      n_cmp++; if (overflow !== m_ovf) begin
        n_err++; $display("FAIL rnd_overflow @%0d: got %b want %b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_async_reset();
    test_resync();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
